// File: rtl/histogram_ram_controller_pkg.sv
// Shared types and constants for the time-correlation histogram RAM controller.
package histogram_ram_controller_pkg;
  localparam int HIST_ADDR_W   = 8;
  localparam int HIST_COUNT_W  = 16;
  localparam int HIST_ZERO_BIN = 128;

  typedef enum logic [2:0] {IDLE, INC_RD, INC_WR, RD_RD, RD_WAIT, CLR} state_e;
endpackage

// File: rtl/histogram_ram_controller_if.sv
// Requester and RAM-side signal bundle; slave is the controller, master the surroundings.
interface histogram_ram_controller_if
  import histogram_ram_controller_pkg::*;
#(
  parameter int ADDR_W  = HIST_ADDR_W,
  parameter int COUNT_W = HIST_COUNT_W
);
  logic               inc_valid;
  logic [ADDR_W-1:0]  inc_addr;
  logic               inc_ready;
  logic               clr_req;
  logic               rd_req;
  logic [ADDR_W-1:0]  rd_addr;
  logic [COUNT_W-1:0] rd_data;
  logic               rd_valid;
  logic               busy;
  logic [15:0]        drop_cnt;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_we;
  logic [COUNT_W-1:0] mem_wdata;
  logic [COUNT_W-1:0] mem_rdata;

  modport slave (
    input  inc_valid, inc_addr, clr_req, rd_req, rd_addr, mem_rdata,
    output inc_ready, rd_data, rd_valid, busy, drop_cnt, mem_addr, mem_we, mem_wdata
  );
  modport master (
    output inc_valid, inc_addr, clr_req, rd_req, rd_addr, mem_rdata,
    input  inc_ready, rd_data, rd_valid, busy, drop_cnt, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/histogram_ram_controller_fifo.sv
// hist_req_fifo: pending bin-increment queue with synchronous flush; head is read combinationally.
module hist_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [PW:0]  wr_q, rd_q;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign head  = mem_q[rd_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_q[PW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push && !full) wr_q <= wr_q + 1'b1;
      if (pop && !empty) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/histogram_ram_controller.sv
// Arbitrates the histogram RAM between increments (read-modify-write), host readout and clear.
// Build option: HIST_SATURATE_EN makes bins stick at all-ones instead of wrapping.
module histogram_ram_controller
  import histogram_ram_controller_pkg::*;
#(
  parameter int ADDR_W     = HIST_ADDR_W,
  parameter int COUNT_W    = HIST_COUNT_W,
  parameter int FIFO_DEPTH = 8
) (
  input logic                        clk,
  input logic                        rst,
  histogram_ram_controller_if.slave  bus
);
  state_e             state_q, arb_nxt;
  logic [ADDR_W-1:0]  addr_q, clr_cnt_q, head;
  logic               clr_pend_q, rd_valid_q;
  logic [COUNT_W-1:0] rd_data_q, inc_val;
  logic [15:0]        drop_cnt_q;
  logic               push, pop, flush, full, empty;

  assign bus.inc_ready = !full && (state_q != CLR) && !clr_pend_q;
  assign push          = bus.inc_valid && bus.inc_ready;
  assign pop           = (state_q == INC_RD);
  assign flush         = ((state_q == IDLE) || (state_q == INC_WR)) && (arb_nxt == CLR);

  hist_req_fifo #(.W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
    .wdata(bus.inc_addr), .head(head), .full(full), .empty(empty)
  );

`ifdef HIST_SATURATE_EN
  assign inc_val = (&bus.mem_rdata) ? bus.mem_rdata : bus.mem_rdata + COUNT_W'(1);
`else
  assign inc_val = bus.mem_rdata + COUNT_W'(1);
`endif

  // INC_WR arbitrates like IDLE so back-to-back increments sustain one per two cycles;
  // an increment arriving with clr_req must not bypass into INC_RD since it gets flushed.
  always_comb begin
    arb_nxt = IDLE;
    if (clr_pend_q)                              arb_nxt = CLR;
    else if (bus.rd_req)                         arb_nxt = RD_RD;
    else if (!empty || (push && !bus.clr_req))   arb_nxt = INC_RD;
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    unique case (state_q)
      INC_RD: bus.mem_addr = head;
      INC_WR: begin
        bus.mem_addr  = addr_q;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = inc_val;
      end
      RD_RD:  bus.mem_addr = bus.rd_addr;
      CLR: begin
        bus.mem_addr = clr_cnt_q;
        bus.mem_we   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      clr_cnt_q  <= '0;
      clr_pend_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      if (bus.inc_valid && !bus.inc_ready && (drop_cnt_q != 16'hFFFF))
        drop_cnt_q <= drop_cnt_q + 16'd1;
      unique case (state_q)
        IDLE, INC_WR: begin
          state_q <= arb_nxt;
          if (arb_nxt == CLR) begin
            clr_pend_q <= 1'b0;
            clr_cnt_q  <= '0;
            drop_cnt_q <= '0;
          end
        end
        INC_RD: begin
          addr_q  <= head;
          state_q <= INC_WR;
        end
        RD_RD:  state_q <= RD_WAIT;
        RD_WAIT: begin
          rd_data_q  <= bus.mem_rdata;
          rd_valid_q <= 1'b1;
          state_q    <= IDLE;
        end
        CLR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (&clr_cnt_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // A request landing on the CLR-entry cycle is kept and serviced by a second sweep.
      if (bus.clr_req) clr_pend_q <= 1'b1;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.drop_cnt = drop_cnt_q;
  assign bus.busy     = (state_q != IDLE) || !empty || clr_pend_q;
endmodule

// File: tb/tb_histogram_ram_controller.sv
// Scoreboarded bench: behavioural RAM + bin-count model, readouts checked by a monitor process.
`timescale 1ns/1ps
module tb_histogram_ram_controller;
  import histogram_ram_controller_pkg::*;
  localparam int AW = HIST_ADDR_W;
  localparam int CW = HIST_COUNT_W;
  localparam int NB = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  histogram_ram_controller_if #(.ADDR_W(AW), .COUNT_W(CW)) bus ();
  histogram_ram_controller #(.ADDR_W(AW), .COUNT_W(CW), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Single-port RAM with synchronous read; pre_we lets the bench seed bins.
  logic [CW-1:0] ram [NB];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [CW-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we)          ram[pre_addr] <= pre_data;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  logic [CW-1:0] ref_bins [NB];
  int            drop_exp;
  logic [CW-1:0] exp_q [$];
  int            addr_q [$];
  int            checks = 0;
  int            passes = 0;

  task automatic check(input string nm, input longint got, input longint exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
  endtask

  function automatic logic [CW-1:0] bumped(input logic [CW-1:0] v);
`ifdef HIST_SATURATE_EN
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
`else
    return v + CW'(1);
`endif
  endfunction

  task automatic monitor();
    logic [CW-1:0] e;
    int a;
    forever begin
      @(negedge clk);
      if (!rst && bus.rd_valid) begin
        if (exp_q.size() == 0) check("unexpected rd_valid (queue depth)", 0, 1);
        else begin
          e = exp_q.pop_front();
          a = addr_q.pop_front();
          check($sformatf("rd bin %0d", a), bus.rd_data, e);
        end
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (bus.busy && n < 1000) begin @(negedge clk); n++; end
    check(nm, bus.busy, 0);
  endtask

  task automatic do_read(input int a, input bit chk_lat);
    int n;
    n = 0;
    exp_q.push_back(ref_bins[a]);
    addr_q.push_back(a);
    bus.rd_req = 1'b1;
    bus.rd_addr = AW'(a);
    do begin @(negedge clk); n++; end while (!bus.rd_valid && n < 20);
    bus.rd_req = 1'b0;
    if (!bus.rd_valid) begin
      check("rd_valid timeout", 0, 1);
      void'(exp_q.pop_back());
      void'(addr_q.pop_back());
    end
    if (chk_lat) check("rd latency", n, 3);
  endtask

  // Drives n consecutive increments; clr_req rides along on iteration clr_at.
  task automatic inc_burst(input int n, input int lo, input int hi, input int clr_at,
                           output int acc);
    acc = 0;
    for (int i = 0; i < n; i++) begin
      bus.inc_valid = 1'b1;
      bus.inc_addr  = AW'($urandom_range(hi, lo));
      bus.clr_req   = (i == clr_at);
      if (bus.inc_ready) begin
        ref_bins[bus.inc_addr] = bumped(ref_bins[bus.inc_addr]);
        acc++;
      end else if (drop_exp < 16'hFFFF) drop_exp++;
      @(negedge clk);
    end
    bus.inc_valid = 1'b0;
    bus.clr_req   = 1'b0;
  endtask

  // Called on the negedge after clr_req was sampled.
  task automatic finish_clear(input string nm);
    int low;
    bit busy_gap;
    low = 0;
    busy_gap = 0;
    while (!bus.inc_ready && low < 400) begin
      if (!bus.busy) busy_gap = 1;
      low++;
      @(negedge clk);
    end
    check({nm, " ready-low cycles >= 257"}, (low >= 257 && low <= 259), 1);
    check({nm, " busy held"}, busy_gap, 0);
    wait_idle({nm, " idle"});
    for (int i = 0; i < NB; i++) ref_bins[i] = '0;
    drop_exp = 0;
  endtask

  task automatic do_clear(input string nm);
    bus.clr_req = 1'b1;
    @(negedge clk);
    bus.clr_req = 1'b0;
    finish_clear(nm);
  endtask

  task automatic preload(input int a, input logic [CW-1:0] d);
    pre_we = 1'b1; pre_addr = AW'(a); pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
    ref_bins[a] = d;
  endtask

  initial begin
    int acc, n, old;
    bit early, wrote;
    bus.inc_valid = 0; bus.inc_addr = '0; bus.clr_req = 0;
    bus.rd_req = 0; bus.rd_addr = '0;
    drop_exp = 0;
    for (int i = 0; i < NB; i++) ref_bins[i] = '0;
    fork monitor(); join_none

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset busy", bus.busy, 0);
    check("reset rd_valid", bus.rd_valid, 0);
    check("reset drop_cnt", bus.drop_cnt, 0);
    check("reset mem_we", bus.mem_we, 0);
    check("reset mem_addr", bus.mem_addr, 0);
    check("reset inc_ready", bus.inc_ready, 1);

    do_clear("init clear");

    // Single increment at the zero-delay bin: write lands two edges after acceptance.
    inc_burst(1, HIST_ZERO_BIN, HIST_ZERO_BIN, -1, acc);
    n = 1;
    while (!bus.mem_we && n < 10) begin @(negedge clk); n++; end
    check("inc write latency", n, 2);
    check("inc write addr", bus.mem_addr, HIST_ZERO_BIN);
    check("inc write data", bus.mem_wdata, 1);
    wait_idle("single idle");
    do_read(HIST_ZERO_BIN, 1);
    do_read(HIST_ZERO_BIN - 1, 1);

    // Burst of 8: no drops, busy falls 16 cycles after the first accept.
    inc_burst(8, 130, 130, -1, acc);
    check("burst accepted", acc, 8);
    n = 0;
    while (bus.busy && n < 50) begin @(negedge clk); n++; end
    check("burst busy-fall cycles", n, 9);
    check("burst drop_cnt", bus.drop_cnt, 0);
    do_read(130, 1);

    // Overflow: 20 gapless increments exceed FIFO drain rate.
    do_clear("pre-overflow clear");
    inc_burst(20, 131, 131, -1, acc);
    wait_idle("overflow idle");
    check("overflow drops seen", (bus.drop_cnt >= 1), 1);
    check("overflow drop_cnt", bus.drop_cnt, drop_exp);
    check("overflow conservation", acc + int'(bus.drop_cnt), 20);
    do_read(131, 1);

    // Priority: read and increment of bin 40 together; read returns the old count first.
    wait_idle("prio idle");
    old = ref_bins[40];
    exp_q.push_back(CW'(old)); addr_q.push_back(40);
    bus.rd_req = 1; bus.rd_addr = 8'd40;
    bus.inc_valid = 1; bus.inc_addr = 8'd40;
    check("prio inc_ready", bus.inc_ready, 1);
    ref_bins[40] = bumped(ref_bins[40]);
    early = 0; wrote = 0; n = 0;
    do begin
      @(negedge clk); n++;
      bus.inc_valid = 0;
      if (bus.mem_we && bus.mem_addr == 8'd40 && !bus.rd_valid) early = 1;
    end while (!bus.rd_valid && n < 20);
    bus.rd_req = 0;
    check("prio rd latency", n, 3);
    check("prio write before rd_valid", early, 0);
    n = 0;
    while (!wrote && n < 10) begin
      @(negedge clk); n++;
      if (bus.mem_we && bus.mem_addr == 8'd40) wrote = 1;
    end
    check("prio inc write after rd", wrote, 1);
    wait_idle("prio done");
    do_read(40, 1);

    // Saturation / wrap at all-ones.
    preload(5, {CW{1'b1}});
    inc_burst(1, 5, 5, -1, acc);
    wait_idle("sat idle");
    do_read(5, 1);

    // Randomized traffic around the zero bin with idle readouts.
    for (int it = 0; it < 40; it++) begin
      inc_burst($urandom_range(6, 1), 120, 135, -1, acc);
      repeat ($urandom_range(3, 0)) @(negedge clk);
      if ($urandom_range(1, 0) == 1) begin
        wait_idle("rand idle");
        do_read($urandom_range(135, 120), 0);
      end
    end
    wait_idle("rand end");
    for (int b = 120; b <= 135; b++) do_read(b, 0);

    // Clear mid-burst, clr_req on the same cycle as an accepted increment.
    inc_burst(5, 60, 70, 4, acc);
    finish_clear("mid-burst clear");
    check("post-clear drop_cnt", bus.drop_cnt, 0);
    for (int b = 0; b < NB; b++) do_read(b, 0);

    // Reset during the sweep leaves upper bins untouched.
    preload(10, 16'd9);
    preload(200, 16'd7);
    bus.clr_req = 1; @(negedge clk); bus.clr_req = 0;
    repeat (100) @(negedge clk);
    rst = 1; @(negedge clk); rst = 0;
    check("abort busy", bus.busy, 0);
    check("abort inc_ready", bus.inc_ready, 1);
    check("abort drop_cnt", bus.drop_cnt, 0);
    ref_bins[10] = '0;
    do_read(10, 1);
    do_read(200, 1);

    repeat (3) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
